// File: rtl/dsp_pkg.sv
// Shared types and step-sequencing helpers for the iterative DSP multiply-accumulate.
// Holds the mode encodings, FSM states and per-mode step counts.
package dsp_pkg;

    typedef enum logic [1:0] {
        MODE_HH  = 2'd0,
        MODE_HF  = 2'd1,
        MODE_FF  = 2'd2,
        MODE_RSV = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned STEPS_HH = 1;
    localparam int unsigned STEPS_HF = 2;
    localparam int unsigned STEPS_FF = 4;

    typedef logic [1:0] step_t;

    // Per-step operand half selection and extension controls for the partial product.
    typedef struct packed {
        logic a_hi;
        logic b_hi;
        logic a_sext;
        logic b_sext;
    } pp_sel_t;

    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == MODE_RSV) ? MODE_FF : mode_e'(m);
    endfunction

    function automatic step_t last_step(input mode_e m);
        case (m)
            MODE_HH: return step_t'(STEPS_HH - 1);
            MODE_HF: return step_t'(STEPS_HF - 1);
            default: return step_t'(STEPS_FF - 1);
        endcase
    endfunction

    function automatic pp_sel_t step_select(input mode_e m, input step_t s);
        pp_sel_t r;
        r = '0;
        case (m)
            MODE_HH: begin
                r.a_sext = 1'b1;
                r.b_sext = 1'b1;
            end
            MODE_HF: begin
                r.a_sext = 1'b1;
                r.b_hi   = s[0];
                r.b_sext = s[0];
            end
            default: begin
                r.a_hi   = s[0];
                r.b_hi   = s[1];
                r.a_sext = s[0];
                r.b_sext = s[1];
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pp_mult_signed.sv
// (AW+1)x(BW+1) signed partial-product multiplier; each operand half is either
// zero-extended (low half) or sign-extended (high half) by its control bit.
module pp_mult_signed #(
    parameter int AW = 8,
    parameter int BW = 8
) (
    input  logic                     a_sext,
    input  logic                     b_sext,
    input  logic [AW-1:0]            a,
    input  logic [BW-1:0]            b,
    output logic signed [AW+BW+1:0]  p
);

    localparam int PW = AW + BW + 2;

    logic signed [AW:0]   a_x;
    logic signed [BW:0]   b_x;
    logic signed [PW-1:0] a_w;
    logic signed [PW-1:0] b_w;

    assign a_x = {a_sext & a[AW-1], a};
    assign b_x = {b_sext & b[BW-1], b};
    assign a_w = PW'(a_x);
    assign b_w = PW'(b_x);
    assign p   = a_w * b_w;

endmodule

// File: rtl/iter_dsp_mac.sv
// Iterative signed multiply-accumulate using one half-width partial product per cycle.
// Optional feature: define ITER_DSP_MAC_SAT_EN for saturating accumulation with sticky sat.
module iter_dsp_mac
    import dsp_pkg::*;
#(
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int ACC_W = N + M + 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             mac,
    input  logic [1:0]       shift_amount,
    input  logic             shift_dir,
    input  logic             clr,
    input  logic [N-1:0]     aa,
    input  logic [M-1:0]     bb,
    output logic             ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out,
    output logic             sat
);

    localparam int N2  = N / 2;
    localparam int M2  = M / 2;
    localparam int PPW = N2 + M2 + 2;
    localparam int PW  = N + M;

    state_e state_q, state_d;
    step_t  step_q, step_d;
    logic   accept;
    logic   done;

    logic [N-1:0]          a_q;
    logic [M-1:0]          b_q;
    mode_e                 mode_q;
    logic                  mac_q;
    logic [1:0]            shamt_q;
    logic                  sdir_q;
    logic signed [PW-1:0]  psum_q;

    pp_sel_t               sel;
    logic [N2-1:0]         a_half;
    logic [M2-1:0]         b_half;
    logic signed [PPW-1:0] pp;
    logic signed [PW-1:0]  pp_w;
    logic signed [PW-1:0]  prod;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] p_sh;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        step_d  = step_q;
        ready   = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: ready = 1'b1;
            ST_RUN: begin
                done  = (step_q == last_step(mode_q));
                ready = done;
            end
            default: ready = 1'b0;
        endcase
        accept = start & ready;
        if (accept) begin
            state_d = ST_RUN;
            step_d  = '0;
        end else if (done) begin
            state_d = ST_IDLE;
            step_d  = '0;
        end else if (state_q == ST_RUN) begin
            step_d = step_q + step_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_HH;
            mac_q   <= 1'b0;
            shamt_q <= '0;
            sdir_q  <= 1'b0;
            psum_q  <= '0;
        end else if (accept) begin
            a_q     <= aa;
            b_q     <= bb;
            mode_q  <= norm_mode(mode);
            mac_q   <= mac;
            shamt_q <= shift_amount;
            sdir_q  <= shift_dir;
            psum_q  <= '0;
        end else if (state_q == ST_RUN) begin
            psum_q  <= prod;
        end
    end

    assign sel    = step_select(mode_q, step_q);
    assign a_half = sel.a_hi ? a_q[N-1:N2] : a_q[N2-1:0];
    assign b_half = sel.b_hi ? b_q[M-1:M2] : b_q[M2-1:0];

    pp_mult_signed #(
        .AW (N2),
        .BW (M2)
    ) u_pp (
        .a_sext (sel.a_sext),
        .b_sext (sel.b_sext),
        .a      (a_half),
        .b      (b_half),
        .p      (pp)
    );

    // Weight the partial product by the positions of the selected halves.
    always_comb begin
        pp_w = PW'(pp);
        if (sel.a_hi) pp_w = pp_w <<< N2;
        if (sel.b_hi) pp_w = pp_w <<< M2;
    end

    assign prod  = psum_q + pp_w;
    assign p_ext = ACC_W'(prod);
    assign p_sh  = sdir_q ? (p_ext <<< shamt_q) : (p_ext >>> shamt_q);

`ifdef ITER_DSP_MAC_SAT_EN
    localparam int AW1 = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] sum_w;
    logic                  ovf;
    logic                  sat_q;

    // One guard bit exposes signed overflow as disagreement of the top two sum bits.
    always_comb begin
        sum_w   = AW1'(acc_q) + AW1'(p_sh);
        ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
        acc_sum = sum_w[ACC_W-1:0];
        if (ovf) acc_sum = sum_w[ACC_W] ? ACC_MIN : ACC_MAX;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (clr) begin
            sat_q <= 1'b0;
        end else if (done && mac_q && ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign sat = sat_q;
`else
    assign acc_sum = acc_q + p_sh;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= done;
            if (done) begin
                acc_q <= (clr || !mac_q) ? p_sh : acc_sum;
            end else if (clr) begin
                acc_q <= '0;
            end
        end
    end

    assign out = acc_q;

endmodule

// File: doc/iter_dsp_mac.md
ITER_DSP_MAC -- requirements
Module: iter_dsp_mac

Interface
REQ-001 Parameters SHALL be: N, 16, A operand width (even); M, 16, B operand width (even); ACC_W, N+M+8, accumulator/output width (>= N+M).
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  request; accepted only when ready=1.
- mode  in  2  0=half x half, 1=half x full, 2=full x full; 3 reserved, treated as 2.
- mac  in  1  1=accumulate, 0=overwrite.
- shift_amount  in  2  product shift 0..3.
- shift_dir  in  1  1=left, 0=arithmetic right.
- clr  in  1  synchronous accumulator clear.
- aa  in  N  signed A operand.
- bb  in  M  signed B operand.
- ready  out  1  can accept start.
- out_valid  out  1  one-cycle result strobe.
- out  out  ACC_W  accumulator value.
- sat  out  1  saturation flag.

Function
REQ-003 Operands SHALL be two's complement; N2=N/2, M2=M/2.
REQ-004 Mode 0 SHALL compute aa[N2-1:0]*bb[M2-1:0] (signed halves) in 1 step; mode 1 SHALL compute aa[N2-1:0]*bb in 2 steps; mode 2 SHALL compute aa*bb in 4 steps.
REQ-005 Each step SHALL use one (N2+1)x(M2+1) signed partial product; low halves zero-extended, high halves sign-extended, weighted by 2^(N2*i+M2*j).
REQ-006 aa, bb, mode, mac, shift_amount, shift_dir SHALL be captured on the accept edge; input changes while busy SHALL have no effect.
REQ-007 FSM SHALL have states IDLE and RUN with step counter; IDLE->RUN on accept, RUN->IDLE after last step unless a new start is accepted on that edge.
REQ-008 ready SHALL be 1 in IDLE and in the last RUN step (back-to-back issue, throughput 1/1, 1/2, 1/4 per cycle for modes 0/1/2).
REQ-009 start while ready=0 SHALL be ignored, not queued.
REQ-010 out_valid SHALL rise exactly k cycles after the accept edge (k=1/2/4) for one cycle, with out updated on that same edge.
REQ-011 Completed product SHALL be shifted per shift_dir/shift_amount, sign-extended to ACC_W, then acc=acc+p if mac=1 else acc=p.
REQ-012 clr SHALL zero acc and sat on the next edge; clr coincident with completion SHALL yield acc=p (mac ignored).
REQ-013 out SHALL hold its value between completions.

Reset
REQ-014 rst_n low SHALL asynchronously force IDLE, step=0, out=0, out_valid=0, sat=0, ready=1, aborting any operation without out_valid.
REQ-015 First accept SHALL be possible on the first edge after rst_n deasserts.

Configuration
REQ-016 With ITER_DSP_MAC_SAT_EN defined, accumulation overflow SHALL clamp acc to signed ACC_W max/min and set sticky sat until clr or reset.
REQ-017 Without ITER_DSP_MAC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and sat SHALL be tied 0.

Structure
REQ-018 Mode encodings, FSM state typedef and step-count-per-mode constants SHALL live in shared package dsp_pkg.
REQ-019 The partial-product multiplier SHALL be sub-module pp_mult_signed with per-operand extension controls.

Verification (N=M=16, default ACC_W unless stated)
REQ-020 Mode 0, aa=0x00FF, bb=0x0003, mac=0 -> out_valid 1 cycle later, out=-3.
REQ-021 Mode 2, aa=0x7FFF, bb=0x7FFF -> out_valid 4 cycles later, out=0x3FFF0001; start held high re-accepts every 4 cycles.
REQ-022 Mode 1, aa=0x0080, bb=0x0100 -> out=-32768 after 2 cycles; mode 0 aa=5, bb=3, shift left 2 -> out=60.
REQ-023 Mode 2 mac=1, aa=bb=1000 twice back-to-back after clr -> out=2000000.
REQ-024 ACC_W=32 with SAT_EN, 0x7FFF*0x7FFF accumulated 3 times -> out=0x7FFFFFFF, sat=1; without SAT_EN -> out=0xBFFD0003, sat=0.
REQ-025 rst_n low during mode-2 step 2 -> out=0, ready=1, no out_valid; next start completes normally.
